ahb5_sram_responder: RTL and testbench
======================================

Name: ahb5_sram_responder

Overview:
- AHB5 subordinate answering the AHB5 manager port of hazard3_cpu_1port, i.e. the responder end of that interface.
- Provides a word-organised SRAM with configurable wait states, ERROR responses for bad accesses, and a single-reservation exclusive-access monitor driving hexokay.
- Used as the memory model in CPU simulation tops. It is also synthesisable as a small on-chip RAM.

Parameters:
- W_ADDR, 32, address width.
- W_DATA, 32, data width (fixed 32; byte lanes = 4).
- DEPTH_WORDS, 1024, number of 32-bit words (power of two).
- BASE_ADDR, 32'h0, byte address of word 0.
- WAIT_STATES, 0, wait cycles inserted in every non-error NONSEQ/SEQ data phase (0..15).

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset; asynchronous, active-high.
- hsel, input, 1: subordinate select.
- haddr, input, W_ADDR: address.
- hwrite, input, 1: write.
- htrans, input, 2: IDLE/BUSY/NONSEQ/SEQ.
- hsize, input, 3: transfer size.
- hburst, input, 3: ignored.
- hprot, input, 4: ignored.
- hmastlock, input, 1: ignored.
- hmaster, input, 8: manager ID used by the exclusive monitor.
- hexcl, input, 1: exclusive transfer.
- hready, input, 1: bus hready; tie to hreadyout when this is the only subordinate.
- hwdata, input, W_DATA: write data, sampled in the data phase.
- hreadyout, output, 1: transfer done.
- hresp, output, 1: 0 = OKAY, 1 = ERROR.
- hexokay, output, 1: exclusive success; valid when hreadyout=1.
- hrdata, output, W_DATA: read data.

Behaviour:
- **Address phase accept:** `hsel & hready & htrans[1]`. The block latches addr, write, size, master, excl, plus an err flag.
- **err flag** is set when any of these hold:
  - hsize > 2;
  - haddr not aligned to hsize;
  - (haddr - BASE_ADDR) >= DEPTH_WORDS*4.
- **IDLE/BUSY, or hsel=0:** next data phase is zero-wait OKAY, hexokay=0.
- **Data-phase FSM states:**
  - IDLE → DATA on accept with err=0.
  - IDLE → ERR1 on accept with err=1.
  - DATA holds hreadyout=0 for WAIT_STATES cycles, then drives hreadyout=1 for one cycle. A new accept in that cycle re-enters DATA or ERR1; otherwise the FSM returns to IDLE.
  - ERR1 drives hreadyout=0, hresp=1 → ERR2.
  - ERR2 drives hreadyout=1, hresp=1 → IDLE or next state.
  - Errors take no wait states, perform no write, and return hrdata=0 and hexokay=0.
- **Writes:**
  - Committed at the final (hreadyout=1) data-phase cycle.
  - Byte enables are decoded from size and addr[1:0]; only enabled lanes of hwdata are written.
- **Reads:**
  - Array read is issued at the address phase. hrdata is valid in the final data-phase cycle.
  - If the read's address phase coincides with the completing data phase of a write to the same word, the written bytes are forwarded (byte-merged) into hrdata.
  - hrdata is held at the last value otherwise. It is 0 after reset.
- **Exclusive monitor:** one reservation {valid, master, word index}.
  - Exclusive read (OKAY): sets the reservation to {1, hmaster, word}; hexokay=1.
  - Exclusive write: succeeds only if the reservation is valid and both master and word match. On success the write is performed and hexokay=1. On failure there is no write, hexokay=0, and the response is still OKAY. The reservation is cleared in both cases.
  - Non-exclusive write by any master to the reserved word that completes with OKAY clears the reservation.
  - Exclusive read and clearing write in the same cycle cannot occur (single data phase).
- **Reset (asynchronous, any time, including mid wait-state or mid-ERROR):**
  - FSM → IDLE, hreadyout=1, hresp=0, hexokay=0, hrdata=0.
  - Reservation is cleared; any pending write is dropped.
  - Memory contents are not reset.

Decomposition:
- Package ahb5_pkg: HTRANS_* and HSIZE_* encodings, HRESP_OKAY/ERROR, and the data-phase state enum {IDLE, DATA, ERR1, ERR2}.
- Sub-module ahb5_excl_monitor:
  - Inputs: set/check/clear strobes, master, word.
  - Outputs: the match flag.

Test Plan:
1. WAIT_STATES=0: word write 0xDEADBEEF at 0x10, then back-to-back read of 0x10 → hreadyout never low; read returns 0xDEADBEEF via forwarding.
2. WAIT_STATES=2: byte write 0xAA at 0x13, then word read of 0x10 (prior 0x11223344) → 2 cycles hreadyout=0 per transfer; read returns 0xAA223344.
3. Read at BASE_ADDR+DEPTH_WORDS*4, and halfword at 0x01 → ERR1 (hresp=1, hreadyout=0) then ERR2 (hresp=1, hreadyout=1); memory unchanged.
4. Exclusive read 0x20 by master 1, then exclusive write 0x20 by master 1 → hexokay=1 on both; data written; a second exclusive write → hexokay=0, no write.
5. Exclusive read 0x20 by master 1, normal write 0x20 by master 2, then exclusive write by master 1 → hexokay=0; memory holds master 2's data.
6. Assert rst during the second wait cycle of a write → hreadyout=1, hresp=0 immediately; target word unchanged; the next read completes normally.

Source files
------------

// File: rtl/ahb5_pkg.sv
// ahb5_pkg
//   Shared AHB5 encodings (HTRANS, HSIZE, HRESP), the data-phase state
//   type used by ahb5_sram_responder, and a byte-lane enable decoder.
package ahb5_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      ERR1,
      ERR2
   } dphase_t;

   // Byte-lane enables of a 32-bit bus for an aligned transfer.
   function automatic logic [3:0] byte_enables(input logic [2:0] size,
                                               input logic [1:0] addr);
      logic [3:0] be;
      case (size)
         HSIZE_BYTE: be = 4'b0001 << addr;
         HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
         default:    be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/ahb5_excl_monitor.sv
// ahb5_excl_monitor
//   Single-reservation exclusive-access monitor.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     set             exclusive read completed: reserve {master, word}
//     check           exclusive write completed: reservation is consumed
//     clr             normal write completed: drop reservation if word matches
//     master, word    manager ID and word index of the completing transfer
//     match           reservation valid and both master and word match
module ahb5_excl_monitor
   import ahb5_pkg::*;
#(
   parameter int unsigned W_WORD = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              set,
   input  logic              check,
   input  logic              clr,
   input  logic [7:0]        master,
   input  logic [W_WORD-1:0] word,
   output logic              match
);

   logic              res_valid;
   logic [7:0]        res_master;
   logic [W_WORD-1:0] res_word;

   assign match = res_valid && (res_master == master) && (res_word == word);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid  <= 1'b0;
         res_master <= '0;
         res_word   <= '0;
      end else if (set) begin
         res_valid  <= 1'b1;
         res_master <= master;
         res_word   <= word;
      end else if (check) begin
         res_valid  <= 1'b0;
      end else if (clr && (res_word == word)) begin
         // Any manager's plain write to the reserved word breaks it.
         res_valid  <= 1'b0;
      end
   end

endmodule

// File: rtl/ahb5_sram_responder.sv
// ahb5_sram_responder
//   AHB5 subordinate: word-organised SRAM with WAIT_STATES wait cycles per
//   transfer, two-cycle ERROR responses for bad size/alignment/range, and
//   an exclusive-access monitor driving hexokay.
//   Ports:
//     clk, rst                    clock, asynchronous active-high reset
//     hsel, haddr, hwrite, htrans, hsize, hmaster, hexcl, hready
//                                 address-phase inputs
//     hburst, hprot, hmastlock    accepted but unused
//     hwdata                      write data (data phase)
//     hreadyout, hresp, hexokay, hrdata
//                                 data-phase response
module ahb5_sram_responder
   import ahb5_pkg::*;
#(
   parameter int unsigned       W_ADDR      = 32,
   parameter int unsigned       W_DATA      = 32,
   parameter int unsigned       DEPTH_WORDS = 1024,
   parameter logic [W_ADDR-1:0] BASE_ADDR   = '0,
   parameter int unsigned       WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hsel,
   input  logic [W_ADDR-1:0] haddr,
   input  logic              hwrite,
   input  logic [1:0]        htrans,
   input  logic [2:0]        hsize,
   input  logic [2:0]        hburst,
   input  logic [3:0]        hprot,
   input  logic              hmastlock,
   input  logic [7:0]        hmaster,
   input  logic              hexcl,
   input  logic              hready,
   input  logic [W_DATA-1:0] hwdata,
   output logic              hreadyout,
   output logic              hresp,
   output logic              hexokay,
   output logic [W_DATA-1:0] hrdata
);

   localparam int unsigned     AW        = $clog2(DEPTH_WORDS);
   localparam logic [W_ADDR:0] MEM_BYTES = (W_ADDR+1)'(DEPTH_WORDS * 4);
   localparam logic [3:0]      WS_CNT    = 4'(WAIT_STATES);

   logic unused_inputs;
   assign unused_inputs = ^{htrans[0], hburst, hprot, hmastlock};

   // ---------------- address phase decode ----------------
   logic              accept;
   logic [W_ADDR-1:0] offset_c;
   logic [AW-1:0]     word_c;
   logic              err_c;

   assign accept   = hsel && hready && htrans[1];
   assign offset_c = haddr - BASE_ADDR;
   assign word_c   = offset_c[AW+1:2];
   // Addresses below BASE_ADDR wrap to a large offset and fail the range test.
   assign err_c    = (hsize > HSIZE_WORD)
                  || ((hsize == HSIZE_HALF) && haddr[0])
                  || ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00))
                  || ({1'b0, offset_c} >= MEM_BYTES);

   // ---------------- latched address phase ----------------
   logic          a_write;
   logic [2:0]    a_size;
   logic [1:0]    a_lo;
   logic [AW-1:0] a_word;
   logic [7:0]    a_master;
   logic          a_excl;
   logic [3:0]    be_q;

   assign be_q = byte_enables(a_size, a_lo);

   // ---------------- data-phase FSM ----------------
   dphase_t    state, state_nx;
   logic [3:0] wcnt, wcnt_nx;
   logic       final_c;
   logic       excl_match;
   logic       wr_commit;

   assign final_c = (state == DATA) && (wcnt == 4'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         wcnt  <= '0;
      end else begin
         state <= state_nx;
         wcnt  <= wcnt_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      wcnt_nx   = wcnt;
      hreadyout = 1'b1;
      hresp     = HRESP_OKAY;
      hexokay   = 1'b0;
      wr_commit = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nx = err_c ? ERR1 : DATA;
               wcnt_nx  = WS_CNT;
            end
         end
         DATA: begin
            if (wcnt != 4'd0) begin
               hreadyout = 1'b0;
               wcnt_nx   = wcnt - 4'd1;
            end else begin
               // Reads always succeed; exclusive writes only with a live reservation.
               hexokay   = a_excl && (!a_write || excl_match);
               wr_commit = a_write && (!a_excl || excl_match);
               if (accept) begin
                  state_nx = err_c ? ERR1 : DATA;
                  wcnt_nx  = WS_CNT;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         ERR1: begin
            hreadyout = 1'b0;
            hresp     = HRESP_ERROR;
            state_nx  = ERR2;
         end
         ERR2: begin
            hresp = HRESP_ERROR;
            if (accept) begin
               state_nx = err_c ? ERR1 : DATA;
               wcnt_nx  = WS_CNT;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // ---------------- exclusive monitor ----------------
   ahb5_excl_monitor #(
      .W_WORD (AW)
   ) u_excl (
      .clk    (clk),
      .rst    (rst),
      .set    (final_c && a_excl && !a_write),
      .check  (final_c && a_excl && a_write),
      .clr    (final_c && !a_excl && a_write),
      .master (a_master),
      .word   (a_word),
      .match  (excl_match)
   );

   // ---------------- storage ----------------
   logic [W_DATA-1:0] mem [DEPTH_WORDS];
   logic [W_DATA-1:0] rd_merged;

   always_ff @(posedge clk) begin
      if (wr_commit) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be_q[i]) mem[a_word][8*i +: 8] <= hwdata[8*i +: 8];
         end
      end
   end

   // A read issued while a write to the same word completes sees the new bytes.
   always_comb begin
      rd_merged = mem[word_c];
      for (int unsigned i = 0; i < 4; i++) begin
         if (wr_commit && (a_word == word_c) && be_q[i]) begin
            rd_merged[8*i +: 8] = hwdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_write  <= 1'b0;
         a_size   <= '0;
         a_lo     <= '0;
         a_word   <= '0;
         a_master <= '0;
         a_excl   <= 1'b0;
         hrdata   <= '0;
      end else if (accept) begin
         a_write  <= hwrite;
         a_size   <= hsize;
         a_lo     <= haddr[1:0];
         a_word   <= word_c;
         a_master <= hmaster;
         a_excl   <= hexcl;
         if (err_c) begin
            hrdata <= '0;
         end else if (!hwrite) begin
            hrdata <= rd_merged;
         end
      end
   end

endmodule

// File: tb/tb_ahb5_sram_responder.sv
// tb_ahb5_sram_responder
//   Directed bench: one zero-wait instance and one two-wait-state instance,
//   each on its own single-subordinate bus (hready tied to hreadyout).
module tb_ahb5_sram_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;   // 0: u_ws0, 1: u_ws2
   logic        hsel = 1'b0;
   logic [31:0] haddr = '0;
   logic        hwrite = 1'b0;
   logic [1:0]  htrans = 2'b00;
   logic [2:0]  hsize = 3'd2;
   logic [7:0]  hmaster = '0;
   logic        hexcl = 1'b0;
   logic [31:0] hwdata = '0;

   logic        ro0, ro2, rs0, rs2, ex0, ex2;
   logic [31:0] rd0, rd2;
   logic        ro, rs, exm;
   logic [31:0] rdm;

   assign ro  = sel ? ro2 : ro0;
   assign rs  = sel ? rs2 : rs0;
   assign exm = sel ? ex2 : ex0;
   assign rdm = sel ? rd2 : rd0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ahb5_sram_responder #(.WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst(rst), .hsel(hsel && !sel), .haddr(haddr), .hwrite(hwrite),
      .htrans(htrans), .hsize(hsize), .hburst(3'd0), .hprot(4'd0), .hmastlock(1'b0),
      .hmaster(hmaster), .hexcl(hexcl), .hready(ro0), .hwdata(hwdata),
      .hreadyout(ro0), .hresp(rs0), .hexokay(ex0), .hrdata(rd0)
   );

   ahb5_sram_responder #(.WAIT_STATES(2)) u_ws2 (
      .clk(clk), .rst(rst), .hsel(hsel && sel), .haddr(haddr), .hwrite(hwrite),
      .htrans(htrans), .hsize(hsize), .hburst(3'd0), .hprot(4'd0), .hmastlock(1'b0),
      .hmaster(hmaster), .hexcl(hexcl), .hready(ro2), .hwdata(hwdata),
      .hreadyout(ro2), .hresp(rs2), .hexokay(ex2), .hrdata(rd2)
   );

   task automatic addr_phase(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                             input logic [7:0] mst, input logic ex);
      hsel = 1'b1; haddr = addr; hwrite = wr; hsize = size;
      hmaster = mst; hexcl = ex; htrans = 2'b10;
   endtask

   // Single transfer; called one cycle after the bus is known idle and ready.
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input logic [7:0] mst, input logic ex,
                       output logic [31:0] rdata, output logic resp1, output logic resp,
                       output logic exok, output int waits);
      addr_phase(wr, addr, size, mst, ex);
      @(posedge clk); #1;
      htrans = 2'b00; hsel = 1'b0; hwdata = wdata;
      resp1 = rs; waits = 0;
      while (!ro && waits < 40) begin @(posedge clk); #1; waits++; end
      rdata = rdm; resp = rs; exok = exm;
      @(posedge clk); #1;
   endtask

   // Write followed by a read whose address phase overlaps the write's data phase.
   task automatic b2b(input logic [31:0] waddr, input logic [2:0] wsize, input logic [31:0] wdata,
                      input logic [31:0] raddr, output int w1, output int w2,
                      output logic [31:0] rdata);
      addr_phase(1'b1, waddr, wsize, 8'd0, 1'b0);
      @(posedge clk); #1;
      addr_phase(1'b0, raddr, 3'd2, 8'd0, 1'b0);
      hwdata = wdata; w1 = 0;
      while (!ro && w1 < 40) begin @(posedge clk); #1; w1++; end
      @(posedge clk); #1;
      htrans = 2'b00; hsel = 1'b0; w2 = 0;
      while (!ro && w2 < 40) begin @(posedge clk); #1; w2++; end
      rdata = rdm;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      n_checks++; if (ro0 !== 1'b1 || ro2 !== 1'b1) begin n_fail++;
         $display("FAIL reset_hreadyout: got %b/%b expected 1/1", ro0, ro2); end
      n_checks++; if (rs0 !== 1'b0 || rs2 !== 1'b0) begin n_fail++;
         $display("FAIL reset_hresp: got %b/%b expected 0/0", rs0, rs2); end
      n_checks++; if (ex0 !== 1'b0 || ex2 !== 1'b0) begin n_fail++;
         $display("FAIL reset_hexokay: got %b/%b expected 0/0", ex0, ex2); end
      n_checks++; if (rd0 !== 32'h0 || rd2 !== 32'h0) begin n_fail++;
         $display("FAIL reset_hrdata: got %h/%h expected 0", rd0, rd2); end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_forward_ws0();
      int w1, w2; logic [31:0] rd;
      sel = 1'b0;
      b2b(32'h10, 3'd2, 32'hDEADBEEF, 32'h10, w1, w2, rd);
      n_checks++; if (w1 !== 0 || w2 !== 0) begin n_fail++;
         $display("FAIL ws0_waits: got %0d/%0d expected 0/0", w1, w2); end
      n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++;
         $display("FAIL ws0_forward: got %h expected deadbeef", rd); end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic r1, r, ek; int w;
      sel = 1'b0;
      xfer(1'b1, 32'h0, 3'd2, 32'h01020304, 8'd0, 1'b0, rd, r1, r, ek, w);
      xfer(1'b0, 32'h1000, 3'd2, 32'h0, 8'd0, 1'b1, rd, r1, r, ek, w);
      n_checks++; if (r1 !== 1'b1 || w !== 1) begin n_fail++;
         $display("FAIL err_range_err1: got resp %b waits %0d expected 1 and 1", r1, w); end
      n_checks++; if (r !== 1'b1 || rd !== 32'h0 || ek !== 1'b0) begin n_fail++;
         $display("FAIL err_range_err2: got resp %b rdata %h exokay %b expected 1 0 0", r, rd, ek); end
      xfer(1'b1, 32'h1, 3'd1, 32'hFFFFFFFF, 8'd0, 1'b0, rd, r1, r, ek, w);
      n_checks++; if (r1 !== 1'b1 || r !== 1'b1 || w !== 1) begin n_fail++;
         $display("FAIL err_misalign: got resp %b/%b waits %0d expected 1/1 1", r1, r, w); end
      xfer(1'b0, 32'h0, 3'd3, 32'h0, 8'd0, 1'b0, rd, r1, r, ek, w);
      n_checks++; if (r1 !== 1'b1 || r !== 1'b1) begin n_fail++;
         $display("FAIL err_size: got resp %b/%b expected 1/1", r1, r); end
      xfer(1'b1, 32'hFFC, 3'd2, 32'hA5A5A5A5, 8'd0, 1'b0, rd, r1, r, ek, w);
      xfer(1'b0, 32'hFFC, 3'd2, 32'h0, 8'd0, 1'b0, rd, r1, r, ek, w);
      n_checks++; if (r !== 1'b0 || rd !== 32'hA5A5A5A5) begin n_fail++;
         $display("FAIL last_word: got resp %b rdata %h expected 0 a5a5a5a5", r, rd); end
      xfer(1'b0, 32'h0, 3'd2, 32'h0, 8'd0, 1'b0, rd, r1, r, ek, w);
      n_checks++; if (rd !== 32'h01020304) begin n_fail++;
         $display("FAIL err_no_write: got %h expected 01020304", rd); end
   endtask

   task automatic test_exclusive();
      logic [31:0] rd; logic r1, r, ek; int w;
      sel = 1'b0;
      xfer(1'b0, 32'h20, 3'd2, 32'h0, 8'd1, 1'b1, rd, r1, r, ek, w);
      n_checks++; if (ek !== 1'b1) begin n_fail++;
         $display("FAIL excl_read_okay: got %b expected 1", ek); end
      xfer(1'b1, 32'h20, 3'd2, 32'hCAFEF00D, 8'd1, 1'b1, rd, r1, r, ek, w);
      n_checks++; if (ek !== 1'b1 || r !== 1'b0) begin n_fail++;
         $display("FAIL excl_write_okay: got exokay %b resp %b expected 1 0", ek, r); end
      xfer(1'b1, 32'h20, 3'd2, 32'h12345678, 8'd1, 1'b1, rd, r1, r, ek, w);
      n_checks++; if (ek !== 1'b0 || r !== 1'b0) begin n_fail++;
         $display("FAIL excl_write_again: got exokay %b resp %b expected 0 0", ek, r); end
      xfer(1'b0, 32'h20, 3'd2, 32'h0, 8'd1, 1'b0, rd, r1, r, ek, w);
      n_checks++; if (rd !== 32'hCAFEF00D) begin n_fail++;
         $display("FAIL excl_data: got %h expected cafef00d", rd); end
   endtask

   task automatic test_excl_broken();
      logic [31:0] rd; logic r1, r, ek; int w;
      sel = 1'b0;
      xfer(1'b0, 32'h20, 3'd2, 32'h0, 8'd1, 1'b1, rd, r1, r, ek, w);
      xfer(1'b1, 32'h20, 3'd2, 32'h0BADC0DE, 8'd2, 1'b0, rd, r1, r, ek, w);
      n_checks++; if (ek !== 1'b0 || r !== 1'b0) begin n_fail++;
         $display("FAIL plain_write: got exokay %b resp %b expected 0 0", ek, r); end
      xfer(1'b1, 32'h20, 3'd2, 32'h99999999, 8'd1, 1'b1, rd, r1, r, ek, w);
      n_checks++; if (ek !== 1'b0) begin n_fail++;
         $display("FAIL excl_after_clear: got %b expected 0", ek); end
      xfer(1'b0, 32'h20, 3'd2, 32'h0, 8'd1, 1'b0, rd, r1, r, ek, w);
      n_checks++; if (rd !== 32'h0BADC0DE) begin n_fail++;
         $display("FAIL excl_broken_data: got %h expected 0badc0de", rd); end
   endtask

   task automatic test_wait_states();
      int w1, w2, w; logic [31:0] rd; logic r1, r, ek;
      sel = 1'b1;
      xfer(1'b1, 32'h10, 3'd2, 32'h11223344, 8'd0, 1'b0, rd, r1, r, ek, w);
      n_checks++; if (w !== 2) begin n_fail++;
         $display("FAIL ws2_single_waits: got %0d expected 2", w); end
      b2b(32'h13, 3'd0, 32'hAA000000, 32'h10, w1, w2, rd);
      n_checks++; if (w1 !== 2 || w2 !== 2) begin n_fail++;
         $display("FAIL ws2_b2b_waits: got %0d/%0d expected 2/2", w1, w2); end
      n_checks++; if (rd !== 32'hAA223344) begin n_fail++;
         $display("FAIL ws2_byte_merge: got %h expected aa223344", rd); end
   endtask

   task automatic test_reset_mid_write();
      logic [31:0] rd; logic r1, r, ek; int w;
      sel = 1'b1;
      xfer(1'b1, 32'h30, 3'd2, 32'h55667788, 8'd0, 1'b0, rd, r1, r, ek, w);
      xfer(1'b0, 32'h30, 3'd2, 32'h0, 8'd0, 1'b0, rd, r1, r, ek, w);
      addr_phase(1'b1, 32'h30, 3'd2, 8'd0, 1'b0);
      @(posedge clk); #1;
      htrans = 2'b00; hsel = 1'b0; hwdata = 32'h0F0F0F0F;
      @(posedge clk); #1;
      n_checks++; if (ro2 !== 1'b0) begin n_fail++;
         $display("FAIL rst_pre_wait: got hreadyout %b expected 0", ro2); end
      rst = 1'b1; #1;
      n_checks++; if (ro2 !== 1'b1 || rs2 !== 1'b0 || ex2 !== 1'b0) begin n_fail++;
         $display("FAIL rst_mid_outputs: got ready %b resp %b exokay %b expected 1 0 0", ro2, rs2, ex2); end
      n_checks++; if (rd2 !== 32'h0) begin n_fail++;
         $display("FAIL rst_mid_hrdata: got %h expected 0", rd2); end
      #1 rst = 1'b0;
      @(posedge clk); #1;
      xfer(1'b0, 32'h30, 3'd2, 32'h0, 8'd0, 1'b0, rd, r1, r, ek, w);
      n_checks++; if (rd !== 32'h55667788 || w !== 2 || r !== 1'b0) begin n_fail++;
         $display("FAIL rst_write_dropped: got %h waits %0d resp %b expected 55667788 2 0", rd, w, r); end
   endtask

   initial begin
      test_reset();
      test_forward_ws0();
      test_errors();
      test_exclusive();
      test_excl_broken();
      test_wait_states();
      test_reset_mid_write();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
